// File: rtl/edge_detector_pair_pkg.sv
// Shared constants and edge classification for the edge detector pair.
// A bit's edge kind is decided from its current detected value and its history.
package edge_detector_pair_pkg;

    localparam int DEF_WIDTH       = 1;
    localparam int DEF_SYNC_STAGES = 0;

    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_kind_e;

    function automatic edge_kind_e classify_edge(input logic s, input logic hist);
        if (s && !hist) begin
            return EDGE_RISE;
        end
        if (!s && hist) begin
            return EDGE_FALL;
        end
        return EDGE_NONE;
    endfunction

endpackage

// File: rtl/edge_detector_pair_if.sv
// Level-in / strobe-out bundle of the edge detector pair.
// The master drives the levels; the slave (the detector) returns the strobes.
interface edge_detector_pair_if
    import edge_detector_pair_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] any_edge;
    logic [WIDTH-1:0] level;

    modport master (
        output in,
        input  rise,
        input  fall,
        input  any_edge,
        input  level
    );

    modport slave (
        input  in,
        output rise,
        output fall,
        output any_edge,
        output level
    );
endinterface

// File: rtl/edge_detector_pair_edge_detect_cell.sv
// One-bit optional synchronizer, history flop and rise/fall decode.
// Strobes here are ungated; the top forces them low during reset.
module edge_detect_cell
    import edge_detector_pair_pkg::*;
#(
    parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_in,
    output logic o_s,
    output logic o_rise,
    output logic o_fall
);
    logic       w_s;
    logic       r_hist;
    edge_kind_e w_kind;

    if (SYNC_STAGES == 0) begin : g_direct
        assign w_s = i_in;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] r_sync;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sync <= {SYNC_STAGES{RESET_VAL}};
            end else begin
                r_sync[0] <= i_in;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    r_sync[k] <= r_sync[k-1];
                end
            end
        end

        assign w_s = r_sync[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hist <= RESET_VAL;
        end else begin
            r_hist <= w_s;
        end
    end

    assign w_kind = classify_edge(w_s, r_hist);
    assign o_s    = w_s;
    assign o_rise = (w_kind == EDGE_RISE);
    assign o_fall = (w_kind == EDGE_FALL);

endmodule

// File: rtl/edge_detector_pair.sv
// Multi-bit rising/falling edge detector built from independent per-bit cells.
// Strobes are combinational from the detected value and history, zero while reset is low.
module edge_detector_pair
    import edge_detector_pair_pkg::*;
#(
    parameter int             WIDTH       = DEF_WIDTH,
    parameter int             SYNC_STAGES = DEF_SYNC_STAGES,
    parameter logic [WIDTH-1:0] RESET_HIST  = '0
) (
    input logic                clk,
    input logic                reset,
    edge_detector_pair_if.slave bus
);
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        edge_detect_cell #(
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_VAL   (RESET_HIST[g])
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .i_in   (bus.in[g]),
            .o_s    (w_s[g]),
            .o_rise (w_rise[g]),
            .o_fall (w_fall[g])
        );
    end

    // Reset gating is asynchronous so a pulse dies the moment reset falls.
    assign bus.rise     = reset ? w_rise : '0;
    assign bus.fall     = reset ? w_fall : '0;
    assign bus.any_edge = reset ? (w_rise | w_fall) : '0;
    assign bus.level    = w_s;

endmodule

// File: tb/tb_edge_detector_pair.sv
// Bench for edge_detector_pair: three configurations checked every cycle against
// a delay-line reference model, plus directed pulses at known cycles.
module tb_edge_detector_pair;
    logic clk;
    logic reset;

    edge_detector_pair_if #(.WIDTH(1)) if0 ();
    edge_detector_pair_if #(.WIDTH(4)) if1 ();
    edge_detector_pair_if #(.WIDTH(8)) if2 ();

    edge_detector_pair #(.WIDTH(1), .SYNC_STAGES(0), .RESET_HIST(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(if0.slave));
    edge_detector_pair #(.WIDTH(4), .SYNC_STAGES(2), .RESET_HIST(4'h0)) u_dut1 (
        .clk(clk), .reset(reset), .bus(if1.slave));
    edge_detector_pair #(.WIDTH(8), .SYNC_STAGES(1), .RESET_HIST(8'h00)) u_dut2 (
        .clk(clk), .reset(reset), .bus(if2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = -1;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: detected value is the input delayed by N clock captures;
    // history is the detected value one capture earlier; reset zeroes both.
    int         NS   [3] = '{0, 2, 1};
    logic [7:0] MASK [3] = '{8'h01, 8'h0f, 8'hff};
    logic [7:0] m_pipe [3][4];
    logic [7:0] m_prev [3];
    logic [7:0] m_in   [3];
    logic       m_rst;

    function automatic logic [7:0] m_s(input int d);
        return (NS[d] == 0) ? m_in[d] : m_pipe[d][NS[d]-1];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_prev[d] = 8'h00;
            for (int k = 0; k < 4; k++) m_pipe[d][k] = 8'h00;
        end
    endtask

    task automatic model_edge();
        if (!m_rst) begin
            model_reset();
        end else begin
            for (int d = 0; d < 3; d++) begin
                m_prev[d] = m_s(d);
                for (int k = 3; k > 0; k--) m_pipe[d][k] = m_pipe[d][k-1];
                m_pipe[d][0] = m_in[d];
            end
        end
    endtask

    function automatic logic [7:0] e_rise(input int d);
        return m_rst ? (m_s(d) & ~m_prev[d] & MASK[d]) : 8'h00;
    endfunction
    function automatic logic [7:0] e_fall(input int d);
        return m_rst ? (~m_s(d) & m_prev[d] & MASK[d]) : 8'h00;
    endfunction

    task automatic compare_all();
        chk("d0_rise",  8'(if0.rise),     e_rise(0));
        chk("d0_fall",  8'(if0.fall),     e_fall(0));
        chk("d0_any",   8'(if0.any_edge), e_rise(0) | e_fall(0));
        chk("d0_level", 8'(if0.level),    m_s(0) & MASK[0]);
        chk("d1_rise",  8'(if1.rise),     e_rise(1));
        chk("d1_fall",  8'(if1.fall),     e_fall(1));
        chk("d1_any",   8'(if1.any_edge), e_rise(1) | e_fall(1));
        chk("d1_level", 8'(if1.level),    m_s(1) & MASK[1]);
        chk("d2_rise",  if2.rise,         e_rise(2));
        chk("d2_fall",  if2.fall,         e_fall(2));
        chk("d2_any",   if2.any_edge,     e_rise(2) | e_fall(2));
        chk("d2_level", if2.level,        m_s(2));
        chk("d2_excl",  if2.rise & if2.fall, 8'h00);
    endtask

    task automatic step(input logic rst, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c);
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        reset  = rst;
        if0.in = a[0];
        if1.in = b[3:0];
        if2.in = c;
        m_in[0] = a & MASK[0];
        m_in[1] = b & MASK[1];
        m_in[2] = c;
        m_rst   = rst;
        if (!rst) model_reset();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        reset  = 1'b0;
        if0.in = '0;
        if1.in = '0;
        if2.in = '0;
        m_rst  = 1'b0;
        for (int d = 0; d < 3; d++) m_in[d] = 8'h00;
        model_reset();

        // Cycles 0-2 in reset, release at 3; d0 pulses 5..9, d1 changes at 3 and 8.
        for (int i = 0; i < 13; i++) begin
            logic       r;
            logic [7:0] a, b;
            r = (i >= 3);
            a = (i >= 5 && i <= 9) ? 8'h01 : 8'h00;
            b = (i < 3) ? 8'h00 : ((i < 8) ? 8'h0a : 8'h06);
            step(r, a, b, 8'h00);
            if (i == 5)  chk("t1_rise5",  8'(if0.rise), 8'h01);
            if (i == 6)  chk("t1_rise6",  8'(if0.rise), 8'h00);
            if (i == 10) chk("t2_fall10", 8'(if0.fall), 8'h01);
            if (i == 10) chk("t2_any10",  8'(if0.any_edge), 8'h01);
            if (i == 11) chk("t2_fall11", 8'(if0.fall), 8'h00);
            if (i == 5)  chk("t4_rise5",  8'(if1.rise), 8'h0a);
            if (i == 6)  chk("t4_rise6",  8'(if1.rise), 8'h00);
            if (i == 10) chk("t4_rise10", 8'(if1.rise), 8'h04);
            if (i == 10) chk("t4_fall10", 8'(if1.fall), 8'h08);
            if (i == 11) chk("t4_fall11", 8'(if1.fall), 8'h00);
        end

        // Input held high through reset: one rise on the release cycle.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h01, 8'h0f, 8'hff);
            chk("t3_rst_rise", 8'(if0.rise), 8'h00);
        end
        step(1'b1, 8'h01, 8'h0f, 8'hff);
        chk("t3_rel_rise", 8'(if0.rise), 8'h01);

        // Reset mid-pulse: strobe must die before the next clock edge.
        reset = 1'b0;
        m_rst = 1'b0;
        model_reset();
        #1;
        chk("t5_kill_rise", 8'(if0.rise), 8'h00);
        compare_all();
        step(1'b1, 8'h01, 8'h0f, 8'hff);
        chk("t5_repulse", 8'(if0.rise), 8'h01);
        step(1'b1, 8'h01, 8'h0f, 8'hff);
        chk("t5_single", 8'(if0.rise), 8'h00);

        for (int i = 0; i < 1000; i++) begin
            logic       r;
            logic [7:0] v;
            r = ($urandom_range(63) != 0);
            v = 8'($urandom);
            step(r, v, 8'($urandom), v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "timeout");
    end
endmodule
